rj_mem_ctrl: RTL and testbench

Initiator/requester for the MSDAP 16x16 coefficient/data memory. It takes single read, write and clear-all commands from the MSDAP control path and drives the memory's level-sensitive en/wr/cntrl_rst interface. It runs a four-phase handshake against w_Done/data_Valid and returns read data to the requester. It sits between the MSDAP main controller and the memory macro, and is the only block that drives the memory's control inputs.

---
 rtl/rj_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_rj_mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rj_mem_ctrl.sv
// rj_mem_ctrl: four-phase initiator driving the MSDAP 16x16 memory (read, write, clear-all).
// Define RJ_MEMCTRL_TIMEOUT_EN to abort a REQ/REL wait after TIMEOUT_CYC cycles.
module rj_mem_ctrl #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              op_done,
   output logic              op_err,
   output logic              mem_start,
   output logic              mem_en,
   output logic              mem_wr,
   output logic              mem_cntrl_rst,
   output logic [ADDR_W-1:0] mem_wr_Addr,
   output logic [ADDR_W-1:0] mem_rd_Addr,
   output logic [DATA_W-1:0] mem_data_In,
   input  logic              mem_w_Done,
   input  logic              mem_data_Valid,
   input  logic [DATA_W-1:0] mem_data_Out
);
   localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, REQ = 2'd2, REL = 2'd3;
   localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_CLR = 2'b10, OP_RSV = 2'b11;
   localparam logic [ADDR_W-1:0] LAST = '1;
   logic [1:0]        state, op;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack, quiet, expired;
   assign ack         = (op == OP_RD) ? mem_data_Valid : mem_w_Done;
   assign quiet       = !mem_w_Done && !mem_data_Valid;
   // the latched address doubles as the clear-all word counter
   assign mem_wr_Addr = addr;
   assign mem_rd_Addr = addr;
   assign mem_data_In = wdata;
`ifdef RJ_MEMCTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tcnt;
   logic          waiting;
   assign waiting = (state == REQ && !ack) || (state == REL && !quiet);
   assign expired = waiting && tcnt == TW'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk)
      tcnt <= (rst || !waiting) ? '0 : tcnt + 1'b1;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign expired        = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INIT;
         op            <= OP_RD;
         addr          <= '0;
         wdata         <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         op_done       <= 1'b0;
         op_err        <= 1'b0;
         mem_start     <= 1'b0;
         mem_en        <= 1'b0;
         mem_wr        <= 1'b0;
         mem_cntrl_rst <= 1'b0;
      end else begin
         mem_start <= 1'b0;
         rsp_valid <= 1'b0;
         op_done   <= 1'b0;
         op_err    <= 1'b0;
         case (state)
            INIT: if (mem_start) begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end else mem_start <= 1'b1;
            IDLE: if (cmd_valid) begin
               op      <= cmd_op;
               addr    <= (cmd_op == OP_CLR) ? '0 : cmd_addr;
               wdata   <= cmd_wdata;
               op_err  <= cmd_op == OP_RSV;
               op_done <= cmd_op == OP_RSV;
               if (cmd_op != OP_RSV) begin
                  state         <= REQ;
                  cmd_ready     <= 1'b0;
                  mem_en        <= 1'b1;
                  mem_wr        <= cmd_op == OP_WR;
                  mem_cntrl_rst <= cmd_op == OP_CLR;
               end
            end
            REQ: if (ack) begin
               state         <= REL;
               mem_en        <= 1'b0;
               mem_wr        <= 1'b0;
               mem_cntrl_rst <= 1'b0;
               rsp_valid     <= op == OP_RD;
               if (op == OP_RD) rsp_data <= mem_data_Out;
            end else if (expired) begin
               state         <= INIT;
               mem_en        <= 1'b0;
               mem_wr        <= 1'b0;
               mem_cntrl_rst <= 1'b0;
               op_err        <= 1'b1;
               op_done       <= 1'b1;
            end
            REL: if (quiet) begin
               if (op == OP_CLR && addr != LAST) begin
                  addr          <= addr + 1'b1;
                  state         <= REQ;
                  mem_en        <= 1'b1;
                  mem_cntrl_rst <= 1'b1;
               end else begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  op_done   <= 1'b1;
               end
            end else if (expired) begin
               state   <= INIT;
               op_err  <= 1'b1;
               op_done <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rj_mem_ctrl.sv
// tb_rj_mem_ctrl: random and directed commands against a behavioural memory and reference model.
module tb_rj_mem_ctrl;
   localparam int AW = 4, DW = 16, DEPTH = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0;
   logic [1:0] cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic cmd_ready, rsp_valid, op_done, op_err, mem_start, mem_en, mem_wr, mem_cntrl_rst;
   logic [AW-1:0] mem_wr_Addr, mem_rd_Addr;
   logic [DW-1:0] rsp_data, mem_data_In, mem_data_Out;
   logic mem_w_Done, mem_data_Valid;
   always #5 clk = ~clk;

   rj_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(15)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .op_done(op_done), .op_err(op_err), .mem_start(mem_start), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_cntrl_rst(mem_cntrl_rst), .mem_wr_Addr(mem_wr_Addr), .mem_rd_Addr(mem_rd_Addr),
      .mem_data_In(mem_data_In), .mem_w_Done(mem_w_Done), .mem_data_Valid(mem_data_Valid),
      .mem_data_Out(mem_data_Out));

   // memory: ack after dly cycles of en, ack held rel_dly cycles after en drops
   logic [DW-1:0] mem [DEPTH];
   int dly = 0, rel_dly = 0, mcnt = 0, hold = 0;
   logic stall = 1'b0, last_rd = 1'b0, ack_now, rd_acc;
   assign rd_acc         = !mem_wr && !mem_cntrl_rst;
   assign ack_now        = mem_en && !stall && mcnt >= dly;
   assign mem_w_Done     = mem_en ? ack_now && !rd_acc : hold > 0 && !last_rd;
   assign mem_data_Valid = mem_en ? ack_now && rd_acc : hold > 0 && last_rd;
   assign mem_data_Out   = mem[mem_rd_Addr];
   always @(posedge clk)
      if (mem_en) begin
         mcnt <= mcnt + 1;
         if (ack_now) begin
            hold    <= rel_dly;
            last_rd <= rd_acc;
            if (mem_cntrl_rst) mem[mem_wr_Addr] <= '0;
            else if (mem_wr) mem[mem_wr_Addr] <= mem_data_In;
         end
      end else begin
         mcnt <= 0;
         if (hold > 0) hold <= hold - 1;
      end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] ref_mem [DEPTH];
   int cur_op = 0;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_wdata = '0, exp_rd = '0;
   logic abort_exp = 1'b0;
   int total = 0, bad = 0, done_cnt = 0, done_base = 0, done_cyc = 0, acc_cyc = 0, prev_acc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // per-cycle compare against the command currently in flight
   int n_acc = 0, n_rsp = 0, clr_next = 0;
   logic en_q = 1'b0;
   logic [AW-1:0] exp_a = '0;
   logic [DW-1:0] last_rsp = '0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         n_acc = 0; n_rsp = 0; clr_next = 0; last_rsp = '0;
      end else begin
         if (mem_en) begin
            if (!en_q) begin
               n_acc++;
               exp_a = (cur_op == 2) ? AW'(clr_next) : cur_addr;
               if (cur_op == 2) clr_next++;
            end
            chk("access", {cmd_ready, mem_wr, mem_cntrl_rst, mem_wr_Addr, mem_rd_Addr},
                {1'b0, cur_op == 1, cur_op == 2, exp_a, exp_a});
            if (cur_op == 1) chk("wdata", mem_data_In, cur_wdata);
         end
         if (rsp_valid) begin
            n_rsp++;
            chk("rsp_data", rsp_data, exp_rd);
            last_rsp = exp_rd;
         end else chk("rsp_hold", rsp_data, last_rsp);
         if (op_done) begin
            chk("op_err", op_err, cur_op == 3 || abort_exp);
            chk("accesses", n_acc, abort_exp ? 1 : cur_op == 3 ? 0 : cur_op == 2 ? DEPTH : 1);
            chk("responses", n_rsp, (cur_op == 0 && !abort_exp) ? 1 : 0);
            done_cnt++; done_cyc = cyc; n_acc = 0; n_rsp = 0; clr_next = 0;
         end else chk("err_alone", op_err, 0);
      end
      en_q = mem_en;
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic issue(input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      while (!cmd_ready && n < 200) begin tick(); n++; end
      chk("ready_wait", cmd_ready, 1);
      cur_op = op; cur_addr = a; cur_wdata = d; exp_rd = ref_mem[a]; done_base = done_cnt;
      cmd_valid = 1'b1; cmd_op = 2'(op); cmd_addr = a; cmd_wdata = d;
      @(posedge clk); #1;
      prev_acc = acc_cyc; acc_cyc = cyc;
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_cnt == done_base && n < limit) begin tick(); n++; end
      chk("done_wait", done_cnt - done_base, 1);
   endtask

   task automatic do_cmd(input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      issue(op, a, d);
      if (op == 1) ref_mem[a] = d;
      if (op == 2) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      wait_done(300);
   endtask

   initial begin
      tick(); tick();
      chk("reset_outs", {cmd_ready, rsp_valid, op_done, op_err, mem_start, mem_en, mem_wr, mem_cntrl_rst,
                         mem_wr_Addr, mem_rd_Addr, mem_data_In, rsp_data}, 0);
      rst = 1'b0;
      tick(); chk("init_start", {mem_start, cmd_ready, mem_en}, 3'b100);
      tick(); chk("init_ready", {mem_start, cmd_ready, mem_en}, 3'b010);
      do_cmd(1, 4'd5, 16'hA5C3);
      do_cmd(0, 4'd5, 16'h0000);
      chk("gap_wr_rd", acc_cyc - prev_acc, 3);
      chk("rd_a5c3", rsp_data, 16'hA5C3);
      for (int i = 0; i < DEPTH; i++) do_cmd(1, AW'(i), 16'h1234);
      do_cmd(2, 4'd3, 16'hFFFF);
      do_cmd(0, 4'd0, 16'h0);
      chk("gap_clear", acc_cyc - prev_acc, 33);
      chk("rd0_clr", rsp_data, 16'h0000);
      do_cmd(0, 4'd7, 16'h0);
      chk("rd7_clr", rsp_data, 16'h0000);
      do_cmd(1, 4'd15, 16'hBEEF);
      do_cmd(3, 4'd2, 16'h0);
      do_cmd(0, 4'd15, 16'h0);
      chk("gap_rsv", acc_cyc - prev_acc, 1);
      chk("rd15", rsp_data, 16'hBEEF);
      for (int i = 0; i < DEPTH; i++) do_cmd(1, AW'(i), 16'h1234);
      issue(2, 4'd0, 16'h0);
      begin
         int n = 0;
         while (!(mem_en && mem_wr_Addr == 4'd9) && n < 100) begin tick(); n++; end
      end
      chk("clr_at9", {mem_en, mem_wr_Addr}, {1'b1, 4'd9});
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_drop", {mem_en, op_done, cmd_ready}, 3'b000);
      tick(); rst = 1'b0;
      tick(); chk("rst_start", {mem_start, cmd_ready, op_done}, 3'b100);
      tick(); chk("rst_ready", {mem_start, cmd_ready, op_done}, 3'b010);
      for (int i = 0; i < 10; i++) ref_mem[i] = '0;
      do_cmd(0, 4'd9, 16'h0);
      chk("rd9_rst", rsp_data, 16'h0000);
      do_cmd(0, 4'd10, 16'h0);
      chk("rd10_rst", rsp_data, 16'h1234);
      stall = 1'b1;
`ifdef RJ_MEMCTRL_TIMEOUT_EN
      abort_exp = 1'b1;
      issue(0, 4'd3, 16'h0);
      wait_done(50);
      chk("to_latency", done_cyc - acc_cyc, 15);
      tick(); chk("to_start", {mem_start, cmd_ready, mem_en}, 3'b100);
      stall = 1'b0;
      abort_exp = 1'b0;
`else
      issue(0, 4'd3, 16'h0);
      repeat (40) tick();
      chk("stall_hold", {mem_en, cmd_ready, done_cnt == done_base}, 3'b101);
      stall = 1'b0;
      wait_done(20);
`endif
      for (int k = 0; k < 150; k++) begin
         int r, op;
         dly = $urandom_range(0, 3);
         rel_dly = $urandom_range(0, 2);
         r = $urandom_range(0, 99);
         op = (r < 45) ? 0 : (r < 85) ? 1 : (r < 93) ? 3 : 2;
         do_cmd(op, AW'($urandom), DW'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
